// File: rtl/serial_framer_pkg.sv
// Shared types and constants for the serial framer: FSM state encoding,
// default sync word, byte-counter width and the even-parity helper.
package serial_framer_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         BYTE_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_DATA,
    ST_PAR
  } state_t;

  // True when data byte plus its trailing parity bit hold an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/serial_framer_sync_detect.sv
// Serial history register plus sync-word compare; clr wipes the history so
// payload bits of a finished frame can never combine with new bits into a false sync.
module sync_detect
  import serial_framer_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d,
  input  logic       clr,
  output logic [7:0] word,
  output logic       match
);

  // The 8-bit window is {hist, d}; the oldest bit would be shifted out before
  // anyone reads it, so only seven bits are stored.
  logic [6:0] hist;

  assign word  = {hist, d};
  assign match = (word == SYNC);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else begin
      hist <= word[6:0];
    end
  end

endmodule

// File: rtl/serial_framer.sv
// Serial byte framer: hunts for SYNC, then assembles LEN MSB-first payload bytes.
// Define SERIAL_FRAMER_PARITY_EN to expect an even-parity bit after each payload byte.
module serial_framer
  import serial_framer_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEFAULT,
  parameter int         LEN  = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iD,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFrameDone,
  output logic       oSync,
  output logic       oErr
);

  state_t                  state;
  logic [2:0]              bit_cnt;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic [7:0]              word;
  logic                    match;
  logic [7:0]              byte_val;
  logic                    byte_ok;
  logic                    parity_fail;
  logic                    last_byte;
  logic                    frame_end;
  logic                    clr;
`ifdef SERIAL_FRAMER_PARITY_EN
  logic [7:0]              par_byte;
`endif

  sync_detect #(
    .SYNC (SYNC)
  ) u_sync_detect (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .d     (iD),
    .clr   (clr),
    .word  (word),
    .match (match)
  );

  assign last_byte = (byte_cnt == BYTE_CNT_W'(LEN - 1));

  // A byte is accepted on the edge that samples its last bit (data bit 8, or
  // the parity bit when parity is enabled).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    byte_ok     = 1'b0;
    parity_fail = 1'b0;
    byte_val    = word;
`ifdef SERIAL_FRAMER_PARITY_EN
    byte_val = par_byte;
    if (state == ST_PAR) begin
      byte_ok     = even_parity_ok(par_byte, iD);
      parity_fail = ~byte_ok;
    end
`else
    byte_ok = (state == ST_DATA) && (bit_cnt == 3'd7);
`endif
  end

  assign frame_end = byte_ok && last_byte;
  assign clr       = frame_end || parity_fail;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ST_HUNT;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      oData      <= 8'h00;
      oValid     <= 1'b0;
      oFrameDone <= 1'b0;
      oSync      <= 1'b0;
      oErr       <= 1'b0;
`ifdef SERIAL_FRAMER_PARITY_EN
      par_byte   <= 8'h00;
`endif
    end else begin
      oValid     <= byte_ok;
      oFrameDone <= frame_end;
      oErr       <= parity_fail;
      if (byte_ok) begin
        oData    <= byte_val;
        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
      end

      case (state)
        ST_HUNT: begin
          if (match) begin
            state    <= ST_DATA;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            oSync    <= 1'b1;
          end
        end
        ST_DATA: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef SERIAL_FRAMER_PARITY_EN
            par_byte <= word;
            state    <= ST_PAR;
`else
            if (last_byte) begin
              state <= ST_HUNT;
              oSync <= 1'b0;
            end
`endif
          end
        end
`ifdef SERIAL_FRAMER_PARITY_EN
        ST_PAR: begin
          if (parity_fail || last_byte) begin
            state <= ST_HUNT;
            oSync <= 1'b0;
          end else begin
            state <= ST_DATA;
          end
        end
`endif
        default: begin
          state <= ST_HUNT;
          oSync <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_framer.sv
// Self-checking bench for serial_framer: a bit-level behavioural model built on a
// pending-bit queue is compared every cycle, plus literal checks on directed frames.
module tb_serial_framer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         LEN  = 4;
`ifdef SERIAL_FRAMER_PARITY_EN
  localparam int         BYTE_BITS = 9;
`else
  localparam int         BYTE_BITS = 8;
`endif

  logic       iCLK   = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iD     = 1'b0;
  logic [7:0] oData;
  logic       oValid;
  logic       oFrameDone;
  logic       oSync;
  logic       oErr;

  int n_checks = 0;
  int n_fail   = 0;

  serial_framer #(
    .SYNC (SYNC),
    .LEN  (LEN)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iD         (iD),
    .oData      (oData),
    .oValid     (oValid),
    .oFrameDone (oFrameDone),
    .oSync      (oSync),
    .oErr       (oErr)
  );

  always #5 iCLK = ~iCLK;

  // Behavioural model: last 8 bits seen, in-frame flag and the bits of the byte in progress.
  logic [7:0] m_win;
  bit         m_in_frame;
  bit         m_pend[$];
  int         m_nbytes;
  logic [7:0] m_data;
  bit         m_valid, m_done, m_err;

  // Monitor records for the literal checks.
  logic [7:0] dut_log[$];
  int         done_cnt, err_cnt, sync_hi_cnt;
  logic [7:0] done_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_win      = 8'h00;
    m_in_frame = 1'b0;
    m_pend.delete();
    m_nbytes   = 0;
    m_data     = 8'h00;
    m_valid    = 1'b0;
    m_done     = 1'b0;
    m_err      = 1'b0;
  endfunction

  function automatic void model_step(input bit b);
    logic [7:0] byt;
    int         ones;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_win   = {m_win[6:0], b};
    if (!m_in_frame) begin
      if (m_win == SYNC) begin
        m_in_frame = 1'b1;
        m_nbytes   = 0;
        m_pend.delete();
      end
    end else begin
      m_pend.push_back(b);
      if (m_pend.size() == BYTE_BITS) begin
        ones = 0;
        for (int i = 0; i < 8; i++) byt[7-i] = m_pend[i];
        for (int i = 0; i < BYTE_BITS; i++) ones += int'(m_pend[i]);
        m_pend.delete();
        if (BYTE_BITS == 8 || (ones % 2) == 0) begin
          m_data  = byt;
          m_valid = 1'b1;
          m_nbytes++;
          if (m_nbytes == LEN) begin
            m_done     = 1'b1;
            m_in_frame = 1'b0;
            m_win      = 8'h00;
          end
        end else begin
          m_err      = 1'b1;
          m_in_frame = 1'b0;
          m_win      = 8'h00;
        end
      end
    end
  endfunction

  // Single compare process: every cycle, away from the active edge.
  always @(negedge iCLK) begin
    check("cycle_outputs", {20'd0, oData, oValid, oFrameDone, oSync, oErr},
          {20'd0, m_data, m_valid, m_done, m_in_frame, m_err});
    if (oValid)     dut_log.push_back(oData);
    if (oFrameDone) begin done_cnt++; done_data = oData; end
    if (oErr)       err_cnt++;
    if (oSync)      sync_hi_cnt++;
  end

  // Driver tasks always resume 1 time unit after a falling edge.
  task automatic send_bit(input bit b);
    iD = b;
    @(posedge iCLK);
    model_step(b);
    @(negedge iCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_payload(input logic [7:0] v, input bit bad_parity);
    send_byte(v);
`ifdef SERIAL_FRAMER_PARITY_EN
    send_bit((^v) ^ bad_parity);
`else
    if (bad_parity) send_bit(1'b0);
`endif
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic clear_logs();
    dut_log.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    sync_hi_cnt = 0;
    done_data   = 8'h00;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    model_reset();
    #1;
    check("reset_outputs_zero", {20'd0, oData, oValid, oFrameDone, oSync, oErr}, 32'd0);
    repeat (2) @(negedge iCLK);
    #1;
    iRST_N = 1'b1;
  endtask

  task automatic compare_log(input string name, input logic [7:0] expq[$]);
    check({name, "_count"}, dut_log.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check({name, "_byte"}, (i < dut_log.size()) ? dut_log[i] : 8'hxx, expq[i]);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] w;
    bit         b;
    logic [7:0] v;

    model_reset();
    clear_logs();
    #1;
    do_reset();

    // Basic frame: sync then 3C F0 11 22.
    clear_logs();
    send_byte(SYNC);
    send_payload(8'h3C, 1'b0);
    send_payload(8'hF0, 1'b0);
    send_payload(8'h11, 1'b0);
    send_payload(8'h22, 1'b0);
    check("basic_done_data", done_data, 8'h22);
    check("basic_sync_low_at_done", oSync, 1'b0);
    send_idle(4);
    compare_log("basic", '{8'h3C, 8'hF0, 8'h11, 8'h22});
    check("basic_done_count", done_cnt, 1);
    check("basic_sync_low_after", oSync, 1'b0);

    // Sync pattern inside payload is data, not a resync.
    do_reset();
    clear_logs();
    send_byte(8'h00);
    send_byte(SYNC);
    for (int i = 0; i < 4; i++) send_payload(SYNC, 1'b0);
    send_idle(3);
    compare_log("no_resync", '{8'hA5, 8'hA5, 8'hA5, 8'hA5});
    check("no_resync_done_count", done_cnt, 1);

    // Two frames back-to-back, no gap bits.
    clear_logs();
    exp_q.delete();
    for (int f = 0; f < 2; f++) begin
      send_byte(SYNC);
      for (int i = 0; i < LEN; i++) begin
        v = 8'($urandom);
        exp_q.push_back(v);
        send_payload(v, 1'b0);
      end
    end
    send_idle(3);
    compare_log("b2b", exp_q);
    check("b2b_done_count", done_cnt, 2);

    // Reset mid-frame: partial frame discarded, new frame only.
    clear_logs();
    send_byte(SYNC);
    send_payload(8'h5A, 1'b0);
    send_payload(8'h69, 1'b0);
    do_reset();
    clear_logs();
    exp_q.delete();
    send_byte(SYNC);
    for (int i = 0; i < LEN; i++) begin
      v = 8'(8'h10 + i);
      exp_q.push_back(v);
      send_payload(v, 1'b0);
    end
    send_idle(3);
    compare_log("mid_reset", exp_q);
    check("mid_reset_done_count", done_cnt, 1);

`ifdef SERIAL_FRAMER_PARITY_EN
    // Good parity then bad parity on byte 3C.
    do_reset();
    clear_logs();
    send_byte(SYNC);
    send_byte(8'h3C);
    send_bit(1'b0);
    check("par_ok_valid", oValid, 1'b1);
    check("par_ok_data", oData, 8'h3C);
    send_byte(8'h3C);
    send_bit(1'b1);
    check("par_bad_err", oErr, 1'b1);
    check("par_bad_no_valid", oValid, 1'b0);
    check("par_bad_sync_low", oSync, 1'b0);
    send_idle(3);
    check("par_valid_count", dut_log.size(), 1);
    check("par_err_count", err_cnt, 1);
`endif

    // 64 random bits that never present the sync window.
    do_reset();
    clear_logs();
    w = 8'h00;
    for (int i = 0; i < 64; i++) begin
      b = bit'($urandom_range(0, 1));
      if ({w[6:0], b} == SYNC) b = ~b;
      w = {w[6:0], b};
      send_bit(b);
    end
    check("nosync_valid_count", dut_log.size(), 0);
    check("nosync_sync_cycles", sync_hi_cnt, 0);

    // Randomized traffic with sprinkled sync words, bad parity and resets.
    do_reset();
    clear_logs();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) send_byte(SYNC);
      else send_payload(8'($urandom), $urandom_range(0, 7) == 0);
    end
    send_idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_framer.md
SERIAL_FRAMER -- requirements
Module: serial_framer

Interface
REQ-001 The block SHALL have parameter SYNC, default 8'hA5: sync word that marks the start of a frame.
REQ-002 The block SHALL have parameter LEN, default 4: payload bytes per frame, legal range 1..255.
REQ-003 The block SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port iRST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port iD, input, 1 bit: serial bit stream, MSB-first, one bit sampled every iCLK rising edge.
REQ-006 The block SHALL have port oData, output, 8 bits: last assembled payload byte, held until the next byte.
REQ-007 The block SHALL have port oValid, output, 1 bit: one-cycle pulse when oData is updated.
REQ-008 The block SHALL have port oFrameDone, output, 1 bit: one-cycle pulse coincident with oValid for byte LEN of a frame.
REQ-009 The block SHALL have port oSync, output, 1 bit: high while the block is inside a frame (not HUNT).
REQ-010 The block SHALL have port oErr, output, 1 bit: one-cycle pulse on parity failure.

Function
REQ-011 The block SHALL implement states HUNT, DATA and PAR (PAR only with parity enabled).
REQ-012 The block SHALL keep an 8-bit shift register that updates every cycle as {sr[6:0], iD}.
REQ-013 In HUNT, when {sr[6:0], iD} equals SYNC, the block SHALL enter DATA with bit count 0 and byte count 0; oSync SHALL rise the following cycle.
REQ-014 In DATA, the block SHALL sample 8 bits; on the 8th bit without parity, oData SHALL take {sr[6:0], iD}, oValid SHALL pulse for 1 cycle, and the byte count SHALL increment.
REQ-015 Latency SHALL be exactly 1 cycle: oValid is high in the cycle after the edge that sampled the last bit of a byte.
REQ-016 When byte count reaches LEN, oFrameDone SHALL pulse with oValid, the state SHALL return to HUNT, and the shift register SHALL clear to 0 so payload bits cannot form a false sync.
REQ-017 Back-to-back frames SHALL be accepted: a sync word starting on the first bit after the last payload bit SHALL be detected.
REQ-018 In DATA, bits equal to SYNC SHALL be treated as payload with no resync.
REQ-019 oValid, oFrameDone and oErr SHALL never be high for more than 1 consecutive cycle.

Reset
REQ-020 Asserting iRST_N low SHALL immediately set state to HUNT, clear the shift register and counters, and drive oData=8'h00 and oValid, oFrameDone, oSync, oErr to 0.
REQ-021 Reset mid-frame SHALL discard the partial frame; after release, the block SHALL require a full new SYNC.

Configuration
REQ-022 With SERIAL_FRAMER_PARITY_EN defined, each payload byte SHALL be followed by one even-parity bit, handled in state PAR.
REQ-023 If the parity bit matches, oValid (and oFrameDone if applicable) SHALL pulse 1 cycle after the parity bit; on mismatch, oErr SHALL pulse, no oValid SHALL occur, and the state SHALL return to HUNT with the shift register cleared.
REQ-024 Without SERIAL_FRAMER_PARITY_EN, PAR SHALL not exist and oErr SHALL be constant 0; the port SHALL remain present.

Structure
REQ-025 Package serial_framer_pkg SHALL hold the state enum type, the default SYNC constant and the byte-count width constant (8).
REQ-026 Sub-module sync_detect (shift register plus SYNC compare, with a clear input) SHALL be the only sub-instance.

Verification
REQ-027 Test: reset, then stream A5,3C,F0,11,22 with LEN=4 -> oValid x4 with oData 3C,F0,11,22; oFrameDone with 22; oSync low afterwards.
REQ-028 Test: stream 00,A5 followed directly by A5,A5,A5,A5 -> payload A5 x4 with no resync, then oFrameDone.
REQ-029 Test: two frames back-to-back with no gap bits -> 8 oValid pulses and 2 oFrameDone pulses.
REQ-030 Test: assert iRST_N low after 2 payload bytes, release, resend full frame -> outputs 0 during reset; only the new frame's 4 bytes appear.
REQ-031 Test (PARITY_EN): byte 3C with parity 0 -> oValid, oData=3C; byte 3C with parity 1 -> oErr pulse, no oValid, oSync low next cycle.
REQ-032 Test: 64 random bits from reset with no A5 window -> oValid and oSync stay 0 throughout.
